// File: rtl/pia_uart_term_pkg.sv
// rtl/pia_uart_term_pkg.sv - shared character constants, FSM encodings and case mapping for pia_uart_term
package pia_uart_term_pkg;

    localparam logic [6:0] ASCII_CR    = 7'h0D;
    localparam logic [6:0] ASCII_LF    = 7'h0A;
    localparam logic [7:0] ASCII_LC_LO = 8'h61;
    localparam logic [7:0] ASCII_LC_HI = 8'h7A;
    localparam logic [6:0] ASCII_CASE  = 7'h20;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

    // The Apple-1 character set has no lowercase, so fold a-z onto A-Z.
    function automatic logic [6:0] to_upper(input logic [7:0] b);
        logic [6:0] c;
        c = b[6:0];
        if (b >= ASCII_LC_LO && b <= ASCII_LC_HI)
            c = b[6:0] - ASCII_CASE;
        return c;
    endfunction

endpackage

// File: rtl/term_uart_rx.sv
// rtl/term_uart_rx.sv - 8N1 UART receiver with input synchronizer; one-cycle rx_valid per good byte
module term_uart_rx
    import pia_uart_term_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic            r_meta, r_line, r_line_d;
    rx_state_t       r_state, w_state_nxt;
    logic [CW-1:0]   r_cnt, w_cnt_nxt;
    logic [2:0]      r_bit, w_bit_nxt;
    logic [7:0]      r_shift, w_shift_nxt;
    logic            w_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta   <= 1'b1;
            r_line   <= 1'b1;
            r_line_d <= 1'b1;
            r_state  <= RX_IDLE;
            r_cnt    <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
        end else begin
            r_meta   <= rxd;
            r_line   <= r_meta;
            r_line_d <= r_line;
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bit    <= w_bit_nxt;
            r_shift  <= w_shift_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CW'(1);
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_valid     = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = '0;
                if (r_line_d && !r_line)
                    w_state_nxt = RX_START;
            end
            RX_START: begin
                if (r_cnt == HALF) begin
                    w_cnt_nxt   = '0;
                    w_bit_nxt   = '0;
                    w_state_nxt = r_line ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                // Counting restarts at the start-bit midpoint, so each wrap lands mid-bit.
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_line, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7)
                        w_state_nxt = RX_STOP;
                end
            end
            RX_STOP: begin
                if (r_cnt == LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RX_IDLE;
                    w_valid     = r_line;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign rx_valid = w_valid;
    assign rx_byte  = r_shift;

endmodule

// File: rtl/pia_uart_term.sv
// rtl/pia_uart_term.sv - UART terminal bridge to the Apple-1 PIA keyboard/display handshakes; TERM_CRLF_EN appends LF after CR
module pia_uart_term
    import pia_uart_term_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic       kbd_rdy,
    input  logic       kbd_ack,
    output logic [6:0] kbd_data,
    input  logic       dsp_rdy,
    output logic       dsp_ack,
    input  logic [6:0] dsp_data
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic       w_rx_valid;
    logic [7:0] w_rx_byte;

    term_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rxd      (uart_rxd),
        .rx_valid (w_rx_valid),
        .rx_byte  (w_rx_byte)
    );

    logic       r_kbd_rdy, r_kbd_wait;
    logic [6:0] r_kbd_data;

    // Bytes arriving while a character is held or the ack has not yet fallen are dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_kbd_rdy  <= 1'b0;
            r_kbd_wait <= 1'b0;
            r_kbd_data <= '0;
        end else if (r_kbd_rdy) begin
            if (kbd_ack) begin
                r_kbd_rdy  <= 1'b0;
                r_kbd_wait <= 1'b1;
            end
        end else if (r_kbd_wait) begin
            if (!kbd_ack)
                r_kbd_wait <= 1'b0;
        end else if (w_rx_valid) begin
            r_kbd_data <= to_upper(w_rx_byte);
            r_kbd_rdy  <= 1'b1;
        end
    end

    assign kbd_rdy  = r_kbd_rdy;
    assign kbd_data = r_kbd_data;

    tx_state_t     r_tx_state, w_tx_state_nxt;
    logic [CW-1:0] r_tx_cnt, w_tx_cnt_nxt;
    logic [2:0]    r_tx_bit, w_tx_bit_nxt;
    logic [7:0]    r_tx_shift, w_tx_shift_nxt;
    logic          r_txd, w_txd_nxt;
    logic          r_dsp_ack;
    logic          w_lf_pend;
    logic          w_accept;

`ifdef TERM_CRLF_EN
    logic r_lf, w_lf_nxt, r_tx_is_cr;
    assign w_lf_pend = r_lf;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lf       <= 1'b0;
            r_tx_is_cr <= 1'b0;
        end else begin
            r_lf <= w_lf_nxt;
            if (w_accept)
                r_tx_is_cr <= (dsp_data == ASCII_CR);
        end
    end
`else
    assign w_lf_pend = 1'b0;
`endif

    assign w_accept = (r_tx_state == TX_IDLE) && dsp_rdy && !r_dsp_ack && !w_lf_pend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
            r_dsp_ack  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_cnt   <= w_tx_cnt_nxt;
            r_tx_bit   <= w_tx_bit_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_txd      <= w_txd_nxt;
            if (w_accept)
                r_dsp_ack <= 1'b1;
            else if (!dsp_rdy)
                r_dsp_ack <= 1'b0;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_cnt_nxt   = r_tx_cnt + CW'(1);
        w_tx_bit_nxt   = r_tx_bit;
        w_tx_shift_nxt = r_tx_shift;
        w_txd_nxt      = r_txd;
`ifdef TERM_CRLF_EN
        w_lf_nxt       = r_lf;
`endif
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_nxt = '0;
                w_txd_nxt    = 1'b1;
                if (w_accept) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_shift_nxt = {1'b0, dsp_data};
                    w_txd_nxt      = 1'b0;
                end
            end
            TX_START: begin
                if (r_tx_cnt == LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = '0;
                    w_tx_state_nxt = TX_DATA;
                    w_txd_nxt      = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (r_tx_cnt == LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_bit_nxt   = r_tx_bit + 3'd1;
                    w_tx_shift_nxt = {1'b0, r_tx_shift[7:1]};
                    if (r_tx_bit == 3'd7) begin
                        w_tx_state_nxt = TX_STOP;
                        w_txd_nxt      = 1'b1;
                    end else begin
                        w_txd_nxt      = r_tx_shift[1];
                    end
                end
            end
            TX_STOP: begin
                if (r_tx_cnt == LAST) begin
                    w_tx_cnt_nxt   = '0;
                    w_tx_state_nxt = TX_IDLE;
                    w_txd_nxt      = 1'b1;
`ifdef TERM_CRLF_EN
                    // Chain the LF frame straight out of the CR stop bit with no idle gap.
                    if (r_lf) begin
                        w_lf_nxt = 1'b0;
                    end else if (r_tx_is_cr) begin
                        w_lf_nxt       = 1'b1;
                        w_tx_shift_nxt = {1'b0, ASCII_LF};
                        w_tx_state_nxt = TX_START;
                        w_txd_nxt      = 1'b0;
                    end
`endif
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    assign uart_txd = r_txd;
    assign dsp_ack  = r_dsp_ack;

endmodule
